sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Two-port arbiter that shares the single-word SDRAM controller interface between the CPU memory path (port A, high priority) and the video/VRAM prefetch path (port B, low priority).
- Sits between the RAM bridge/video fetch logic and the SDRAM controller.
- Sequences each access through the controller's request/flag/idle handshake.
- Gates refresh so a refresh never starts mid-grant.
- Bounds port-B starvation with a fairness counter.

Parameters:
- ADDR_W, 25, width of the controller word address.
- MAX_A_RUN, 4, consecutive A grants allowed while B is pending before B is forced a grant (1..15).

Ports:
- clock  in  1  system/SDRAM clock
- reset  in  1  asynchronous, active-high
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A 1=write, 0=read; sampled with a_req
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  16  port A write data
- a_ack  out  1  one-cycle completion pulse for port A
- a_rdata  out  16  port A read data; valid with a_ack, held until the next A read completes
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same directions/widths/meanings as A, for port B
- refresh_in  in  1  one-cycle refresh strobe from the bus-idle detector
- ctl_address  out  ADDR_W  to controller
- ctl_access_num  out  10  constant 10'h001
- ctl_data_in  out  16  to controller
- ctl_write_request  out  1  to controller
- ctl_read_request  out  1  to controller
- ctl_enable_refresh  out  1  to controller
- ctl_data_out  in  16  from controller
- ctl_write_flag  in  1  from controller
- ctl_read_flag  in  1  from controller
- ctl_idle  in  1  from controller
- grant_b  out  1  1 while port B owns the controller (debug/status)

Behaviour:
- Reset values: all acks, ctl_write_request, ctl_read_request, ctl_enable_refresh, grant_b = 0; rdata, ctl_address, ctl_data_in = 0; state IDLE; run counter 0; refresh_pending 0.
- Latched command: on grant, the winner's we/addr/wdata are registered. ctl_* outputs drive only from these latches; requester inputs may change after grant.
- States:
  - IDLE
    - If refresh_pending and ctl_idle -> REFRESH.
    - Else if ctl_idle and any req -> ISSUE with winner latched.
    - Otherwise stay.
  - ISSUE
    - Drive write_request or read_request = 1 per latched we.
    - Go to XFER on the first cycle the matching flag = 1.
  - XFER
    - Requests = 0.
    - Read: capture ctl_data_out into the winner's rdata on every cycle read_flag = 1; the last captured word is final.
    - Go to DONE when the matching flag returns to 0.
  - DONE
    - Pulse the winner's ack for exactly 1 cycle, then -> IDLE.
  - REFRESH
    - Drive ctl_enable_refresh = 1 for exactly 1 cycle, clear refresh_pending, -> IDLE.
- Refresh: refresh_in sets refresh_pending in any state; a strobe coinciding with the clear leaves pending set. Refresh beats a new grant in IDLE; no grant is issued in the same cycle refresh is started.
- Arbitration (IDLE, ctl_idle = 1):
  - Only A pending -> A.
  - Only B pending -> B.
  - Both pending: A wins unless run counter = MAX_A_RUN, in which case B wins.
  - Run counter:
    - Increments (saturating at MAX_A_RUN) on each A grant while b_req = 1.
    - Clears on any B grant, or when b_req = 0 at an A grant.
- Minimum latency from req (IDLE, controller idle) to ack = 4 cycles plus controller latency: grant, ISSUE, XFER, DONE.
- A requester deasserting req after grant does not abort; the access completes and the ack is still pulsed. Ack is never issued to a non-granted port.
- A requester must drop req the cycle after ack; a req still high in IDLE is treated as a new request.
- Reset mid-access: everything returns to reset values immediately; no ack is issued for the aborted access.
- grant_b = 1 in ISSUE/XFER/DONE when the latched winner is B.

Test Plan:
- Single A write: a_req = 1, a_we = 1, a_addr = 0x00123, a_wdata = 0x00A5 -> ctl_write_request high with ctl_address = 0x00123, ctl_data_in = 0x00A5 until write_flag; one a_ack pulse; b_ack stays 0.
- B read: b_req, b_addr = 0x1C000; controller returns 0xBEEF during read_flag -> b_rdata = 0xBEEF on b_ack; a_rdata unchanged.
- Simultaneous A+B held continuously, MAX_A_RUN = 4 -> grant order A,A,A,A,B,A,A,A,A,B; grant_b high only during B accesses.
- refresh_in pulsed during an A access in XFER -> ctl_enable_refresh pulses once after DONE→IDLE, before the next grant; pending A/B waits one cycle.
- Reset asserted in XFER of a B read -> all outputs 0 on the same edge; no b_ack; next A request is serviced normally.
- a_req dropped the cycle after grant -> access still completes; a_ack pulses once; no second access is issued.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one single-word SDRAM controller between a high-priority
// CPU port (A) and a low-priority video prefetch port (B). Each access walks the
// controller's request/flag/idle handshake, refresh is only started between
// grants, and a run counter bounds how long B can be starved by back-to-back A.
module sdram_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int MAX_A_RUN = 4
) (
  input  logic              clock,
  input  logic              reset,
  // port A (CPU path, high priority)
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  // port B (video prefetch path, low priority)
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  // refresh strobe from the bus-idle detector
  input  logic              refresh_in,
  // SDRAM controller interface
  output logic [ADDR_W-1:0] ctl_address,
  output logic [9:0]        ctl_access_num,
  output logic [15:0]       ctl_data_in,
  output logic              ctl_write_request,
  output logic              ctl_read_request,
  output logic              ctl_enable_refresh,
  input  logic [15:0]       ctl_data_out,
  input  logic              ctl_write_flag,
  input  logic              ctl_read_flag,
  input  logic              ctl_idle,
  // status
  output logic              grant_b
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE,
    S_REFRESH
  } state_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_A_RUN);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_winner_b;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [3:0]        r_run_cnt;
  logic              r_refresh_pending;
  logic [15:0]       r_a_rdata;
  logic [15:0]       r_b_rdata;

  logic w_start_refresh;
  logic w_grant;
  logic w_pick_b;
  logic w_flag;

  // Refresh has priority over a new grant, and both need an idle controller.
  assign w_start_refresh = (r_state == S_IDLE) && ctl_idle && r_refresh_pending;
  assign w_grant         = (r_state == S_IDLE) && ctl_idle && !r_refresh_pending
                           && (a_req || b_req);
  // B wins when it is alone, or when A has used up its run while B waited.
  assign w_pick_b        = b_req && (!a_req || (r_run_cnt == MAX_RUN));
  // Handshake flag belonging to the latched command direction.
  assign w_flag          = r_we ? ctl_write_flag : ctl_read_flag;

  assign ctl_address    = r_addr;
  assign ctl_data_in    = r_wdata;
  assign ctl_access_num = 10'h001;
  assign a_rdata        = r_a_rdata;
  assign b_rdata        = r_b_rdata;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/ack outputs, all decoded from the current state.
  always_comb begin
    w_state_next       = r_state;
    ctl_write_request  = 1'b0;
    ctl_read_request   = 1'b0;
    ctl_enable_refresh = 1'b0;
    a_ack              = 1'b0;
    b_ack              = 1'b0;
    grant_b            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_refresh) begin
          w_state_next = S_REFRESH;
        end else if (w_grant) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ctl_write_request = r_we;
        ctl_read_request  = !r_we;
        grant_b           = r_winner_b;
        if (w_flag) begin
          w_state_next = S_XFER;
        end
      end
      S_XFER: begin
        grant_b = r_winner_b;
        if (!w_flag) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        grant_b      = r_winner_b;
        a_ack        = !r_winner_b;
        b_ack        = r_winner_b;
        w_state_next = S_IDLE;
      end
      S_REFRESH: begin
        ctl_enable_refresh = 1'b1;
        w_state_next       = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Latch the winner's command at grant so requesters may change inputs afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_winner_b <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_winner_b <= w_pick_b;
      r_we       <= w_pick_b ? b_we    : a_we;
      r_addr     <= w_pick_b ? b_addr  : a_addr;
      r_wdata    <= w_pick_b ? b_wdata : a_wdata;
    end
  end

  // Fairness run counter: counts A grants taken while B was waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_cnt <= '0;
    end else if (w_grant) begin
      if (w_pick_b || !b_req) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != MAX_RUN) begin
        r_run_cnt <= r_run_cnt + 4'd1;
      end
    end
  end

  // Refresh request latch; a strobe arriving as it is consumed keeps it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_refresh_pending <= 1'b0;
    end else begin
      r_refresh_pending <= refresh_in || (r_refresh_pending && (r_state != S_REFRESH));
    end
  end

  // Read data capture: every flagged beat in XFER overwrites, so the last one sticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if ((r_state == S_XFER) && !r_we && ctl_read_flag) begin
      if (r_winner_b) begin
        r_b_rdata <= ctl_data_out;
      end else begin
        r_a_rdata <= ctl_data_out;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed + randomized bench with a behavioural controller
// responder, a word-memory reference model and a fairness-order model.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int ADDR_W    = 25;
  localparam int MAX_A_RUN = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              gb;
  } cmd_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              a_req, a_we, a_ack;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_wdata, a_rdata;
  logic              b_req, b_we, b_ack;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_wdata, b_rdata;
  logic              refresh_in;
  logic [ADDR_W-1:0] ctl_address;
  logic [9:0]        ctl_access_num;
  logic [15:0]       ctl_data_in, ctl_data_out;
  logic              ctl_write_request, ctl_read_request, ctl_enable_refresh;
  logic              ctl_write_flag, ctl_read_flag, ctl_idle;
  logic              grant_b;

  int checks = 0;
  int errors = 0;

  // responder / monitor state
  int   cyc = 0, a_ack_cnt = 0, b_ack_cnt = 0, ref_cnt = 0, ref_cyc = 0;
  int   bad_cnt = 0, a_ack_cyc = 0;
  int   ph = 0, wcnt = 0, fcnt = 0;
  cmd_t cur;
  cmd_t cmd_q[$];
  int   cmd_cyc_q[$];
  logic [15:0] dev_mem   [logic [ADDR_W-1:0]];
  logic [15:0] model_mem [logic [ADDR_W-1:0]];

  sdram_arbiter #(.ADDR_W(ADDR_W), .MAX_A_RUN(MAX_A_RUN)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .refresh_in(refresh_in),
    .ctl_address(ctl_address), .ctl_access_num(ctl_access_num),
    .ctl_data_in(ctl_data_in), .ctl_write_request(ctl_write_request),
    .ctl_read_request(ctl_read_request), .ctl_enable_refresh(ctl_enable_refresh),
    .ctl_data_out(ctl_data_out), .ctl_write_flag(ctl_write_flag),
    .ctl_read_flag(ctl_read_flag), .ctl_idle(ctl_idle),
    .grant_b(grant_b)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] dev_word(input logic [ADDR_W-1:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [15:0] model_word(input logic [ADDR_W-1:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  function automatic int q_cyc(input int idx);
    if (idx < cmd_cyc_q.size()) return cmd_cyc_q[idx];
    return -1;
  endfunction

  // Controller responder and event monitor, sampled 2ns after the rising edge.
  always @(posedge clock) begin
    #2;
    cyc++;
    if (reset) begin
      ph = 0; ctl_idle = 1'b1; ctl_write_flag = 1'b0; ctl_read_flag = 1'b0;
      ctl_data_out = 16'h0;
    end else begin
      if (a_ack) begin a_ack_cnt++; a_ack_cyc = cyc; end
      if (b_ack) b_ack_cnt++;
      if ((a_ack && b_ack) || (a_ack && grant_b) || (b_ack && !grant_b)) bad_cnt++;
      if (ctl_enable_refresh) begin ref_cnt++; ref_cyc = cyc; end
      case (ph)
        0: if (ctl_write_request || ctl_read_request) begin
             cur.we = ctl_write_request; cur.addr = ctl_address;
             cur.data = ctl_data_in; cur.gb = grant_b;
             cmd_q.push_back(cur); cmd_cyc_q.push_back(cyc);
             ctl_idle = 1'b0; wcnt = $urandom_range(0, 2); ph = 1;
           end
        1: if (wcnt == 0) begin
             fcnt = $urandom_range(2, 3);
             if (cur.we) ctl_write_flag = 1'b1; else ctl_read_flag = 1'b1;
             ctl_data_out = ~dev_word(cur.addr);
             ph = 2;
           end else wcnt--;
        2: if (fcnt == 1) begin
             ctl_write_flag = 1'b0; ctl_read_flag = 1'b0;
             if (cur.we) dev_mem[cur.addr] = cur.data;
             ph = 3;
           end else begin
             fcnt--;
             ctl_data_out = (fcnt == 1) ? dev_word(cur.addr) : ~dev_word(cur.addr);
           end
        default: begin ctl_idle = 1'b1; ph = 0; end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input int idx, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [15:0] data,
                           input logic gb);
    cmd_t c;
    c = '0;
    if (idx < cmd_q.size()) c = cmd_q[idx];
    check({tag, "_we"},   32'(c.we),   32'(we));
    check({tag, "_addr"}, 32'(c.addr), 32'(addr));
    check({tag, "_data"}, 32'(c.data), 32'(data));
    check({tag, "_gb"},   32'(c.gb),   32'(gb));
  endtask

  task automatic wait_ack(input bit port_b, input int start_cnt, input string tag);
    int n;
    n = 0;
    while (((port_b ? b_ack_cnt : a_ack_cnt) == start_cnt) && n < 80) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ack_seen"}, 32'(n < 80), 32'd1);
  endtask

  task automatic new_cmd(output logic we, output logic [ADDR_W-1:0] addr, output logic [15:0] d);
    we   = 1'($urandom_range(0, 1));
    addr = 25'h100 + 25'($urandom_range(0, 7));
    d    = 16'($urandom);
  endtask

  initial begin
    logic [ADDR_W-1:0] t_addr;
    logic              t_we;
    logic [15:0]       t_data;
    int n, k, run, base_a, base_b, base_q, base_ref;
    bit exp_b [10];

    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    refresh_in = 0; ctl_idle = 1; ctl_write_flag = 0; ctl_read_flag = 0; ctl_data_out = 0;
    dev_mem[25'h1C000] = 16'hBEEF;
    model_mem[25'h1C000] = 16'hBEEF;

    // reset state
    reset = 1;
    repeat (3) @(negedge clock);
    check("rst_a_ack", 32'(a_ack), 0);
    check("rst_b_ack", 32'(b_ack), 0);
    check("rst_wreq", 32'(ctl_write_request), 0);
    check("rst_rreq", 32'(ctl_read_request), 0);
    check("rst_refresh", 32'(ctl_enable_refresh), 0);
    check("rst_grant_b", 32'(grant_b), 0);
    check("rst_addr", 32'(ctl_address), 0);
    check("rst_wdata", 32'(ctl_data_in), 0);
    check("rst_a_rdata", 32'(a_rdata), 0);
    check("rst_b_rdata", 32'(b_rdata), 0);
    check("access_num", 32'(ctl_access_num), 32'h1);
    reset = 0;
    @(negedge clock);

    // single A write
    base_a = a_ack_cnt; base_b = b_ack_cnt; base_q = cmd_q.size();
    a_we = 1; a_addr = 25'h00123; a_wdata = 16'h00A5; a_req = 1;
    wait_ack(0, base_a, "a_write");
    a_req = 0;
    model_mem[25'h00123] = 16'h00A5;
    repeat (5) @(negedge clock);
    check("a_write_ack_cnt", 32'(a_ack_cnt), 32'(base_a + 1));
    check("a_write_no_b_ack", 32'(b_ack_cnt), 32'(base_b));
    check("a_write_cmd_cnt", 32'(cmd_q.size()), 32'(base_q + 1));
    check_cmd("a_write", base_q, 1'b1, 25'h00123, 16'h00A5, 1'b0);

    // B read of a preloaded word
    base_a = a_ack_cnt; base_b = b_ack_cnt; base_q = cmd_q.size();
    b_we = 0; b_addr = 25'h1C000; b_wdata = 16'h1234; b_req = 1;
    wait_ack(1, base_b, "b_read");
    check("b_read_rdata", 32'(b_rdata), 32'(model_word(25'h1C000)));
    b_req = 0;
    check("b_read_a_rdata", 32'(a_rdata), 0);
    repeat (3) @(negedge clock);
    check("b_read_no_a_ack", 32'(a_ack_cnt), 32'(base_a));
    check_cmd("b_read", base_q, 1'b0, 25'h1C000, 16'h1234, 1'b1);

    // both ports held continuously with random commands: fairness order
    run = 0;
    for (int i = 0; i < 10; i++) begin
      if (run == MAX_A_RUN) begin exp_b[i] = 1; run = 0; end
      else begin exp_b[i] = 0; run++; end
    end
    new_cmd(t_we, t_addr, t_data); a_we = t_we; a_addr = t_addr; a_wdata = t_data;
    new_cmd(t_we, t_addr, t_data); b_we = t_we; b_addr = t_addr; b_wdata = t_data;
    base_a = a_ack_cnt; base_b = b_ack_cnt; base_q = cmd_q.size();
    k = 0; n = 0;
    a_req = 1; b_req = 1;
    while (k < 10 && n < 600) begin
      @(negedge clock);
      n++;
      if (a_ack_cnt != base_a) begin
        base_a = a_ack_cnt;
        check($sformatf("mix%0d_port", k), 0, 32'(exp_b[k]));
        check_cmd($sformatf("mix%0d", k), base_q + k, a_we, a_addr, a_wdata, 1'b0);
        if (a_we) model_mem[a_addr] = a_wdata;
        else check($sformatf("mix%0d_a_rdata", k), 32'(a_rdata), 32'(model_word(a_addr)));
        k++;
        new_cmd(t_we, t_addr, t_data); a_we = t_we; a_addr = t_addr; a_wdata = t_data;
      end
      if (k < 10 && b_ack_cnt != base_b) begin
        base_b = b_ack_cnt;
        check($sformatf("mix%0d_port", k), 1, 32'(exp_b[k]));
        check_cmd($sformatf("mix%0d", k), base_q + k, b_we, b_addr, b_wdata, 1'b1);
        if (b_we) model_mem[b_addr] = b_wdata;
        else check($sformatf("mix%0d_b_rdata", k), 32'(b_rdata), 32'(model_word(b_addr)));
        k++;
        new_cmd(t_we, t_addr, t_data); b_we = t_we; b_addr = t_addr; b_wdata = t_data;
      end
      if (k == 10) begin a_req = 0; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    check("mix_grants", 32'(k), 32'd10);
    repeat (4) @(negedge clock);

    // refresh strobe during an A transfer, with B waiting
    base_ref = ref_cnt; base_a = a_ack_cnt; base_b = b_ack_cnt; base_q = cmd_q.size();
    a_we = 0; a_addr = 25'h101; a_req = 1;
    n = 0;
    while (!(ctl_read_flag && !ctl_read_request) && n < 80) begin
      @(negedge clock);
      n++;
    end
    check("ref_xfer_seen", 32'(n < 80), 32'd1);
    refresh_in = 1;
    t_data = 16'($urandom);
    b_we = 1; b_addr = 25'h102; b_wdata = t_data; b_req = 1;
    @(negedge clock);
    refresh_in = 0;
    wait_ack(0, base_a, "ref_a");
    check("ref_a_rdata", 32'(a_rdata), 32'(model_word(25'h101)));
    a_req = 0;
    wait_ack(1, base_b, "ref_b");
    b_req = 0;
    model_mem[25'h102] = t_data;
    check("ref_count", 32'(ref_cnt - base_ref), 32'd1);
    check("ref_after_done", 32'(ref_cyc), 32'(a_ack_cyc + 2));
    check("ref_before_grant", 32'(q_cyc(base_q + 1)), 32'(ref_cyc + 2));
    check_cmd("ref_b", base_q + 1, 1'b1, 25'h102, t_data, 1'b1);
    repeat (3) @(negedge clock);

    // refresh strobe coinciding with the refresh cycle leaves one more pending
    base_ref = ref_cnt;
    refresh_in = 1;
    @(negedge clock);
    refresh_in = 0;
    n = 0;
    while (!ctl_enable_refresh && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("dref_first_seen", 32'(n < 20), 32'd1);
    refresh_in = 1;
    @(negedge clock);
    refresh_in = 0;
    repeat (8) @(negedge clock);
    check("dref_count", 32'(ref_cnt - base_ref), 32'd2);

    // reset in the middle of a B read transfer
    base_b = b_ack_cnt;
    b_we = 0; b_addr = 25'h103; b_req = 1;
    n = 0;
    while (!(grant_b && ctl_read_flag && !ctl_read_request) && n < 80) begin
      @(negedge clock);
      n++;
    end
    check("rstx_xfer_seen", 32'(n < 80), 32'd1);
    #2;
    reset = 1;
    #1;
    check("rstx_b_ack", 32'(b_ack), 0);
    check("rstx_grant_b", 32'(grant_b), 0);
    check("rstx_rreq", 32'(ctl_read_request), 0);
    check("rstx_wreq", 32'(ctl_write_request), 0);
    check("rstx_refresh", 32'(ctl_enable_refresh), 0);
    check("rstx_addr", 32'(ctl_address), 0);
    check("rstx_wdata", 32'(ctl_data_in), 0);
    check("rstx_a_rdata", 32'(a_rdata), 0);
    check("rstx_b_rdata", 32'(b_rdata), 0);
    b_req = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    repeat (6) @(negedge clock);
    check("rstx_no_b_ack", 32'(b_ack_cnt), 32'(base_b));

    // A read serviced normally after reset
    base_a = a_ack_cnt; base_q = cmd_q.size();
    a_we = 0; a_addr = 25'h1C000; a_wdata = 16'h0; a_req = 1;
    wait_ack(0, base_a, "post_rst_a");
    check("post_rst_a_rdata", 32'(a_rdata), 32'(model_word(25'h1C000)));
    a_req = 0;
    check_cmd("post_rst_a", base_q, 1'b0, 25'h1C000, 16'h0, 1'b0);
    repeat (3) @(negedge clock);

    // A drops its request right after grant: access still completes once
    base_a = a_ack_cnt; base_q = cmd_q.size();
    t_addr = 25'h104; t_data = 16'($urandom);
    a_we = 1; a_addr = t_addr; a_wdata = t_data; a_req = 1;
    @(negedge clock);
    a_req = 0; a_we = 0; a_addr = ~t_addr; a_wdata = ~t_data;
    wait_ack(0, base_a, "drop");
    model_mem[t_addr] = t_data;
    repeat (10) @(negedge clock);
    check("drop_ack_cnt", 32'(a_ack_cnt), 32'(base_a + 1));
    check("drop_cmd_cnt", 32'(cmd_q.size()), 32'(base_q + 1));
    check_cmd("drop", base_q, 1'b1, t_addr, t_data, 1'b0);

    // read the dropped-request write back through A
    base_a = a_ack_cnt;
    a_we = 0; a_addr = t_addr; a_req = 1;
    wait_ack(0, base_a, "drop_rb");
    check("drop_rb_rdata", 32'(a_rdata), 32'(model_word(t_addr)));
    a_req = 0;
    repeat (3) @(negedge clock);

    check("bad_ack_events", 32'(bad_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
